// File: rtl/led_seq_pkg.sv
// led_seq_pkg -- shared types and constants for the LED sequencer.
//
// Contents:
//   led_mode_t      2-bit mode code (BINARY=0, CHASE=1, BOUNCE=2, BLINK=3)
//   LED_ALL_ON/OFF  whole-bank LED patterns
//   next_mode()     mode that follows the given one (BLINK wraps to BINARY)
//   first_pattern() LED pattern shown right after entering a mode
//   one_hot()       single lit LED at a 2-bit position
package led_seq_pkg;

   typedef enum logic [1:0] {
      MODE_BINARY = 2'd0,
      MODE_CHASE  = 2'd1,
      MODE_BOUNCE = 2'd2,
      MODE_BLINK  = 2'd3
   } led_mode_t;

   localparam logic [3:0] LED_ALL_ON  = 4'hF;
   localparam logic [3:0] LED_ALL_OFF = 4'h0;

   function automatic led_mode_t next_mode(input led_mode_t m);
      led_mode_t n;
      case (m)
         MODE_BINARY: n = MODE_CHASE;
         MODE_CHASE:  n = MODE_BOUNCE;
         MODE_BOUNCE: n = MODE_BLINK;
         default:     n = MODE_BINARY;
      endcase
      return n;
   endfunction

   // CHASE and BOUNCE start with LED x0 lit; BINARY shows step 0 and BLINK
   // starts in its dark phase, so both of those start with everything off.
   function automatic logic [3:0] first_pattern(input led_mode_t m);
      logic [3:0] p;
      case (m)
         MODE_CHASE, MODE_BOUNCE: p = 4'h1;
         default:                 p = LED_ALL_OFF;
      endcase
      return p;
   endfunction

   function automatic logic [3:0] one_hot(input logic [1:0] pos);
      return 4'b0001 << pos;
   endfunction

endpackage

// File: rtl/led_sequencer_if.sv
// led_sequencer_if -- board-side signals of the LED sequencer.
//
// Signals:
//   btn    raw push-button, asynchronous, active-high
//   led    4-bit pattern to pins x3..x0 (led[3] drives x3)
//   green  status LED
//   mode   current mode code, for debug
//
// Modports:
//   master  the sequencer: drives the LEDs and mode, reads the button
//   slave   the board/test side: drives the button, observes the rest
interface led_sequencer_if;
   import led_seq_pkg::*;

   logic       btn;
   logic [3:0] led;
   logic       green;
   led_mode_t  mode;

   modport master (input btn, output led, output green, output mode);
   modport slave  (output btn, input led, input green, input mode);

endinterface

// File: rtl/led_sequencer_btn_debounce.sv
// btn_debounce -- synchronizer, debouncer and press-pulse generator.
//
// Parameters:
//   DEB_CYCLES  consecutive stable samples needed to accept a new level (2..2^20)
// Ports:
//   clk     system clock, rising edge
//   resetn  synchronous active-low reset
//   btn_in  raw asynchronous button, active-high
//   level   debounced button level
//   press   one-cycle pulse on each 0->1 change of level
module btn_debounce
   import led_seq_pkg::*;
#(
   parameter int DEB_CYCLES = 120000
) (
   input  logic clk,
   input  logic resetn,
   input  logic btn_in,
   output logic level,
   output logic press
);

   localparam int CW = $clog2(DEB_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

   logic          sync1_reg;
   logic          sync2_reg;
   logic          level_reg;
   logic          press_reg;
   logic [CW-1:0] cnt_reg;

   // cnt_reg counts consecutive synchronized samples that disagree with the
   // current level; the DEB_CYCLES-th such sample flips the level. The press
   // pulse is registered on the same edge that the level rises.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         sync1_reg <= 1'b0;
         sync2_reg <= 1'b0;
         level_reg <= 1'b0;
         press_reg <= 1'b0;
         cnt_reg   <= '0;
      end else begin
         sync1_reg <= btn_in;
         sync2_reg <= sync1_reg;
         press_reg <= 1'b0;
         if (sync2_reg == level_reg) begin
            cnt_reg <= '0;
         end else if (cnt_reg == CNT_LAST) begin
            level_reg <= sync2_reg;
            press_reg <= sync2_reg;
            cnt_reg   <= '0;
         end else begin
            cnt_reg <= cnt_reg + 1'b1;
         end
      end
   end

   assign level = level_reg;
   assign press = press_reg;

endmodule

// File: rtl/led_sequencer.sv
// led_sequencer -- four-mode LED pattern sequencer stepped by a button.
//
// Each debounced press advances BINARY -> CHASE -> BOUNCE -> BLINK -> BINARY
// and restarts the pattern; a prescaler tick steps the current pattern.
//
// Parameters:
//   TICK_DIV    clk cycles per pattern step (2..2^24)
//   DEB_CYCLES  button debounce length in clk cycles (2..2^20)
// Ports:
//   clk     system clock, rising edge
//   resetn  synchronous active-low reset
//   bus     led_sequencer_if.master: btn in; led, green, mode out
//
// Build option: define LED_SEQ_BREATHE_EN to turn green into a breathing
// PWM output; without it green is held at 1.
module led_sequencer
   import led_seq_pkg::*;
#(
   parameter int TICK_DIV   = 1500000,
   parameter int DEB_CYCLES = 120000
) (
   input  logic                   clk,
   input  logic                   resetn,
   led_sequencer_if.master        bus
);

   localparam int PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

   logic          press;
   logic          deb_level_unused; // only press events matter to the FSM
   logic          tick;
   logic [PW-1:0] presc_reg;
   led_mode_t     mode_reg;
   logic [3:0]    step_reg;
   logic          dir_reg;
   logic [3:0]    led_reg;
   logic [1:0]    bpos_next;
   logic          bdir_next;
   logic          green_reg;

   btn_debounce #(
      .DEB_CYCLES (DEB_CYCLES)
   ) u_deb (
      .clk    (clk),
      .resetn (resetn),
      .btn_in (bus.btn),
      .level  (deb_level_unused),
      .press  (press)
   );

   assign tick = (presc_reg == PRESC_LAST);

   // BOUNCE walks 0..3..0 using step_reg[1:0] as the position; the direction
   // flips on arriving at either end so the end LEDs are shown only once.
   always_comb begin
      bpos_next = dir_reg ? (step_reg[1:0] - 2'd1) : (step_reg[1:0] + 2'd1);
      bdir_next = dir_reg;
      if (bpos_next == 2'd3) begin
         bdir_next = 1'b1;
      end else if (bpos_next == 2'd0) begin
         bdir_next = 1'b0;
      end
   end

   // Mode FSM, prescaler and pattern generator. A press wins over a
   // coincident tick: the tick is dropped and the new mode starts fresh.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         mode_reg  <= MODE_BINARY;
         presc_reg <= '0;
         step_reg  <= '0;
         dir_reg   <= 1'b0;
         led_reg   <= LED_ALL_OFF;
      end else if (press) begin
         mode_reg  <= next_mode(mode_reg);
         presc_reg <= '0;
         step_reg  <= '0;
         dir_reg   <= 1'b0;
         led_reg   <= first_pattern(next_mode(mode_reg));
      end else begin
         presc_reg <= tick ? '0 : presc_reg + 1'b1;
         if (tick) begin
            case (mode_reg)
               MODE_BINARY: begin
                  step_reg <= step_reg + 4'd1;
                  led_reg  <= step_reg + 4'd1;
               end
               MODE_CHASE: begin
                  step_reg <= {2'b00, step_reg[1:0] + 2'd1};
                  led_reg  <= one_hot(step_reg[1:0] + 2'd1);
               end
               MODE_BOUNCE: begin
                  step_reg <= {2'b00, bpos_next};
                  dir_reg  <= bdir_next;
                  led_reg  <= one_hot(bpos_next);
               end
               default: begin
                  // BLINK: step_reg[0] records whether the bank is lit.
                  step_reg <= {3'b000, ~step_reg[0]};
                  led_reg  <= step_reg[0] ? LED_ALL_OFF : LED_ALL_ON;
               end
            endcase
         end
      end
   end

`ifdef LED_SEQ_BREATHE_EN
   logic [7:0] pwm_cnt_reg;
   logic [7:0] duty_reg;
   logic       duty_dir_reg;

   // Breathing status LED: duty ramps up and down by 16 per tick, clamping
   // at 0 and 255. It runs independently of presses.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         pwm_cnt_reg  <= 8'd0;
         duty_reg     <= 8'd0;
         duty_dir_reg <= 1'b0;
         green_reg    <= 1'b0;
      end else begin
         pwm_cnt_reg <= pwm_cnt_reg + 8'd1;
         green_reg   <= (pwm_cnt_reg < duty_reg);
         if (tick) begin
            if (!duty_dir_reg) begin
               if (duty_reg >= 8'd239) begin
                  duty_reg     <= 8'd255;
                  duty_dir_reg <= 1'b1;
               end else begin
                  duty_reg <= duty_reg + 8'd16;
               end
            end else begin
               if (duty_reg <= 8'd16) begin
                  duty_reg     <= 8'd0;
                  duty_dir_reg <= 1'b0;
               end else begin
                  duty_reg <= duty_reg - 8'd16;
               end
            end
         end
      end
   end
`else
   always_ff @(posedge clk) begin
      if (!resetn) begin
         green_reg <= 1'b1;
      end else begin
         green_reg <= 1'b1;
      end
   end
`endif

   assign bus.led   = led_reg;
   assign bus.green = green_reg;
   assign bus.mode  = mode_reg;

endmodule

// File: doc/led_sequencer.md
LED_SEQUENCER -- requirements
Module: led_sequencer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1500000, clk cycles per pattern step (8 Hz at 12 MHz); legal range 2..2^24.
REQ-002 SHALL have parameter DEB_CYCLES, default 120000, consecutive stable cycles needed to accept a button level; legal range 2..2^20.
REQ-003 SHALL have port clk  in  1  system clock; one clock, and all logic on its rising edge.
REQ-004 SHALL have port resetn  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port btn  in  1  raw push-button, asynchronous, active-high.
REQ-006 SHALL have port led  out  4  pattern to pins x3..x0 (led[3] drives x3).
REQ-007 SHALL have port green  out  1  status LED.
REQ-008 SHALL have port mode  out  2  current mode code, for debug.

Function
REQ-009 SHALL pass btn through a 2-FF synchronizer before any other use.
REQ-010 SHALL debounce as follows: the debounced level takes the synchronized value only after DEB_CYCLES consecutive equal samples that differ from the current level; any mismatch restarts the count at 0.
REQ-011 SHALL generate a 1-cycle press pulse on each 0->1 transition of the debounced level; release generates nothing.
REQ-012 SHALL run a prescaler from 0 to TICK_DIV-1; tick is asserted when the count equals TICK_DIV-1, and the count then wraps to 0.
REQ-013 SHALL implement the mode FSM BINARY(0) -> CHASE(1) -> BOUNCE(2) -> BLINK(3) -> BINARY, advancing one state per press.
REQ-014 SHALL, on press, in the same cycle: advance the mode, clear the prescaler, step and dir to 0, and set led to the first pattern of the new mode on the next edge.
REQ-015 SHALL give press priority when press and tick coincide; that tick is discarded.
REQ-016 SHALL, in BINARY: led = step, with step incrementing per tick and wrapping 15->0.
REQ-017 SHALL, in CHASE: led = 1<<pos, with pos 0,1,2,3,0,...
REQ-018 SHALL, in BOUNCE: led = 1<<pos, with pos sequence 0,1,2,3,2,1,0,1,...; dir flips at 3 and at 0 with no end-repeat.
REQ-019 SHALL, in BLINK: led alternate 4'h0 and 4'hF per tick, starting at 4'h0.
REQ-020 SHALL register led; led changes exactly one cycle after the tick cycle.
REQ-021 SHALL drive mode directly from the FSM state register.

Reset
REQ-022 SHALL, when resetn=0 at a clk edge, clear: synchronizer, debounce counter and level, prescaler, step, dir, led=4'h0, mode=BINARY.
REQ-023 SHALL discard any in-progress debounce or press on reset; the first press after release needs a full DEB_CYCLES.

Configuration
REQ-024 SHALL use macro LED_SEQ_BREATHE_EN.
REQ-025 SHALL, with LED_SEQ_BREATHE_EN undefined, hold green at constant 1 (reset value 1).
REQ-026 SHALL, with LED_SEQ_BREATHE_EN defined, make green an 8-bit PWM output:
- free-running 8-bit pwm counter; green = (pwm_cnt < duty)
- duty ramps 0->255 then 255->0 in steps of 16 (saturating at the ends), one step per tick
- reset: duty=0, pwm counter 0, green=0
- press does not affect the breathe state.

Structure
REQ-027 SHALL place the mode enum (2-bit, the four codes above) and the pattern constants (LED_ALL_ON=4'hF, LED_ALL_OFF=4'h0) in shared package led_seq_pkg.
REQ-028 SHALL implement the synchronizer, debouncer and press-pulse generation in sub-module btn_debounce (params DEB_CYCLES; ports clk, resetn, btn_in, level, press).

Verification (bench params TICK_DIV=4, DEB_CYCLES=3)
REQ-029 SHALL cover reset and BINARY wrap: release reset, no button -> mode=0; led=0,1,2,...,15,0 on successive ticks, one tick every 4 cycles.
REQ-030 SHALL cover bounce rejection: btn 1,0,1,0 each for 2 cycles, then low -> no press, mode stays 0.
REQ-031 SHALL cover a clean press: btn held high for 10 cycles -> exactly one press; mode=1; led=4'h1 the next cycle, then 2,4,8,1 on ticks.
REQ-032 SHALL cover BOUNCE and BLINK:
- after 2 presses, BOUNCE led sequence = 1,2,4,8,4,2,1,2
- after a further press, BLINK led = 0,F,0,F
- after a further press, mode=0.
REQ-033 SHALL cover press on a tick cycle: press aligned with prescaler=3 -> mode advances, step=0, and the next tick occurs 4 cycles later.
REQ-034 SHALL cover reset mid-pattern: resetn=0 for 1 cycle in CHASE with pos=2 -> led=0 and mode=0 on the next edge; with LED_SEQ_BREATHE_EN, green=0 and duty ramps 0,16,32 on ticks.
